pipe_carry_adder: RTL and testbench

- Pipelined, segmented add/subtract block for the FLE carry fabric.
- Splits a WIDTH-bit ripple chain into SEG-bit segments. Each segment's carry-out is registered and consumed as the next stage's carry-in, so the block is the receiving end of the FLE COUT→CIN hop.
- Operands are skewed into the pipeline and results de-skewed out. A valid/ready handshake provides global stall.
- Used where long carry chains break timing: wide counters, accumulators, comparators.

---
 rtl/pipe_carry_pkg.sv | 26 ++
 rtl/pipe_carry_seg.sv | 66 ++++++
 rtl/pipe_carry_adder.sv | 123 ++++++++++++
 tb/tb_pipe_carry_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_carry_pkg.sv
// Shared sizing helpers and stage-control record for the segmented carry pipeline.
// Pure declarations: no latency, no flow control.
// Slice bounds put the narrow remainder segment on top when WIDTH is not a multiple of SEG.
package pipe_carry_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic zpart;
    } stage_ctl_t;

    function automatic int nstages(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_lo(input int k, input int seg);
        return k * seg;
    endfunction

    function automatic int seg_hi(input int k, input int seg, input int width);
        int hi;
        hi = (k + 1) * seg - 1;
        return (hi > width - 1) ? width - 1 : hi;
    endfunction

endpackage

// File: rtl/pipe_carry_seg.sv
// One carry segment: P/G ripple over SW bits, registered sum/carry/valid (and zero partial).
// Latency 1 cycle.
// Holds every register while en is low.
module pipe_carry_seg
    import pipe_carry_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          C,
    input  logic          R,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  stage_ctl_t    ctl_i,
    output logic [SW-1:0] sum,
    output stage_ctl_t    ctl_o,
    output logic          ovf
);

    logic [SW:0]   cv;
    logic [SW-1:0] sum_d;
    logic          valid_q;
    logic          carry_q;

    always_comb begin
        cv    = '0;
        sum_d = '0;
        cv[0] = ctl_i.carry;
        for (int i = 0; i < SW; i++) begin
            sum_d[i]  = a[i] ^ b[i] ^ cv[i];
            cv[i + 1] = (a[i] ^ b[i]) ? cv[i] : (a[i] & b[i]);
        end
    end

    // ovf is only meaningful on the top segment: carry into MSB differs from carry out
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            sum     <= '0;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            ovf     <= 1'b0;
        end else if (en) begin
            sum     <= sum_d;
            valid_q <= ctl_i.valid;
            carry_q <= cv[SW];
            ovf     <= cv[SW] ^ cv[SW - 1];
        end
    end

`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
    logic zpart_q;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            zpart_q <= 1'b0;
        end else if (en) begin
            zpart_q <= ctl_i.zpart & (sum_d == '0);
        end
    end

    assign ctl_o = '{valid: valid_q, carry: carry_q, zpart: zpart_q};
`else
    assign ctl_o = '{valid: valid_q, carry: carry_q, zpart: ctl_i.zpart};
`endif

endmodule

// File: rtl/pipe_carry_adder.sv
// Pipelined segmented add/subtract; optional zero flag Z under PIPE_CARRY_ADDER_ZERO_FLAG_EN.
// Latency NSTAGES cycles, throughput 1 beat/cycle.
// Global stall: whole pipe holds while O_VALID && !O_READY; I_READY mirrors the enable.
module pipe_carry_adder
    import pipe_carry_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             CIN,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             O_VALID,
`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
    output logic             Z,
`endif
    input  logic             O_READY
);

    localparam int NSTAGES = nstages(WIDTH, SEG);

    logic             en;
    logic [WIDTH-1:0] bb;
    stage_ctl_t       ctl_in [NSTAGES];
    stage_ctl_t       ctl    [NSTAGES];
    logic             seg_ovf[NSTAGES];

    assign en      = !O_VALID || O_READY;
    assign I_READY = en;
    assign bb      = SUB ? ~B : B;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, SEG);
        localparam int HI = seg_hi(k, SEG, WIDTH);
        localparam int SW = HI - LO + 1;
        localparam int D  = NSTAGES - 1 - k;

        logic [SW-1:0] a_k;
        logic [SW-1:0] b_k;
        logic [SW-1:0] s_k;

        if (k == 0) begin : g_first
            assign a_k       = A[HI:LO];
            assign b_k       = bb[HI:LO];
            assign ctl_in[k] = '{valid: I_VALID, carry: CIN, zpart: 1'b1};
        end else begin : g_skew
            // Operand slice k waits k cycles so it meets the carry from stage k-1
            logic [SW-1:0] a_sk [k];
            logic [SW-1:0] b_sk [k];

            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    for (int j = 0; j < k; j++) begin
                        a_sk[j] <= '0;
                        b_sk[j] <= '0;
                    end
                end else if (en) begin
                    a_sk[0] <= A[HI:LO];
                    b_sk[0] <= bb[HI:LO];
                    for (int j = 1; j < k; j++) begin
                        a_sk[j] <= a_sk[j - 1];
                        b_sk[j] <= b_sk[j - 1];
                    end
                end
            end

            assign a_k       = a_sk[k - 1];
            assign b_k       = b_sk[k - 1];
            assign ctl_in[k] = ctl[k - 1];
        end

        pipe_carry_seg #(
            .SW (SW)
        ) u_seg (
            .C     (C),
            .R     (R),
            .en    (en),
            .a     (a_k),
            .b     (b_k),
            .ctl_i (ctl_in[k]),
            .sum   (s_k),
            .ctl_o (ctl[k]),
            .ovf   (seg_ovf[k])
        );

        if (D == 0) begin : g_top
            assign SUM[HI:LO] = s_k;
        end else begin : g_deskew
            logic [SW-1:0] d_sk [D];

            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    for (int j = 0; j < D; j++) begin
                        d_sk[j] <= '0;
                    end
                end else if (en) begin
                    d_sk[0] <= s_k;
                    for (int j = 1; j < D; j++) begin
                        d_sk[j] <= d_sk[j - 1];
                    end
                end
            end

            assign SUM[HI:LO] = d_sk[D - 1];
        end
    end

    assign COUT    = ctl[NSTAGES - 1].carry;
    assign O_VALID = ctl[NSTAGES - 1].valid;
    assign OVF     = seg_ovf[NSTAGES - 1];
`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
    assign Z       = ctl[NSTAGES - 1].zpart;
`endif

endmodule

// File: tb/tb_pipe_carry_adder.sv
// Directed bench for pipe_carry_adder (32-bit, 8-bit segments) with a result scoreboard.
module tb_pipe_carry_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        z;
    } exp_t;

    logic        C = 1'b0;
    logic        R;
    logic [31:0] A;
    logic [31:0] B;
    logic        SUB;
    logic        CIN;
    logic        I_VALID;
    logic        I_READY;
    logic [31:0] SUM;
    logic        COUT;
    logic        OVF;
    logic        O_VALID;
    logic        O_READY;
    logic        z_obs;
`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
    logic        Z;
    assign z_obs = Z;
`else
    assign z_obs = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t held;
    bit   hold_pend = 1'b0;

    pipe_carry_adder #(
        .WIDTH (32),
        .SEG   (8)
    ) dut (
        .C       (C),
        .R       (R),
        .A       (A),
        .B       (B),
        .SUB     (SUB),
        .CIN     (CIN),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .SUM     (SUM),
        .COUT    (COUT),
        .OVF     (OVF),
        .O_VALID (O_VALID),
`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
        .Z       (Z),
`endif
        .O_READY (O_READY)
    );

    always #5 C = ~C;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic cin);
        exp_t        e;
        logic [31:0] bv;
        logic [32:0] r;
        bv     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, bv} + {32'd0, cin};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (a[31] == bv[31]) && (r[31] != a[31]);
        e.z    = (r[31:0] == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller must be at posedge+#1; returns at posedge+#1 of the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin);
        A = a; B = b; SUB = sub; CIN = cin; I_VALID = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge C);
            if (I_READY === 1'b1) begin
                exp_q.push_back(model(a, b, sub, cin));
                @(posedge C);
                #1;
                I_VALID = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $error("FAIL send_timeout: observed I_READY %0b expected 1", I_READY);
        I_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge C);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge C);
        #1;
    endtask

    task automatic measure_latency(input string tag);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge C);
            if (O_VALID === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk(tag, 64'(lat), 64'd4);
    endtask

    // Output-side scoreboard and stall-hold checks
    always @(negedge C) begin
        exp_t e;
        if (R === 1'b1 && O_VALID === 1'b1) begin
            if (hold_pend) begin
                chk("hold_sum",  64'(SUM),  64'(held.sum));
                chk("hold_cout", 64'(COUT), 64'(held.cout));
                chk("hold_ovf",  64'(OVF),  64'(held.ovf));
            end
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_bad++;
                $error("FAIL extra_output: observed SUM %0h expected no output", SUM);
            end
            if (exp_q.size() != 0 && O_READY === 1'b1) begin
                e = exp_q.pop_front();
                chk("sum",  64'(SUM),  64'(e.sum));
                chk("cout", 64'(COUT), 64'(e.cout));
                chk("ovf",  64'(OVF),  64'(e.ovf));
`ifdef PIPE_CARRY_ADDER_ZERO_FLAG_EN
                chk("z",    64'(z_obs), 64'(e.z));
`endif
            end
            hold_pend = (O_READY !== 1'b1);
            held      = '{sum: SUM, cout: COUT, ovf: OVF, z: z_obs};
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int idx;
        int cyc;
        bit acc;
        logic [31:0] ra;
        logic [31:0] rb;

        R = 1'b0; A = '0; B = '0; SUB = 1'b0; CIN = 1'b0;
        I_VALID = 1'b0; O_READY = 1'b1;

        // Reset then idle
        repeat (3) @(posedge C);
        #1;
        chk("rst_hold_ovalid", 64'(O_VALID), 64'd0);
        R = 1'b1;
        @(negedge C);
        chk("rst_ovalid", 64'(O_VALID), 64'd0);
        chk("rst_sum",    64'(SUM),     64'd0);
        chk("rst_cout",   64'(COUT),    64'd0);
        chk("rst_ovf",    64'(OVF),     64'd0);
        chk("rst_iready", 64'(I_READY), 64'd1);
        @(posedge C);
        #1;

        // Cross-segment carry, with latency
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        measure_latency("latency");
        drain();

        // Subtract, overflow, full ripple, assorted edges
        send(32'd5,         32'd7,         1'b1, 1'b1);
        send(32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1);
        send(32'd100,       32'd100,       1'b1, 1'b1);
        send(32'h8000_0000, 32'd1,         1'b1, 1'b1);
        send(32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0);
        drain();

        // Back-to-back stream with a 5-cycle downstream stall mid-stream
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 200) begin
            ra = 32'h0101_0101 * (idx + 1) + 32'hF0;
            rb = $urandom;
            A = ra; B = rb; SUB = idx[0]; CIN = idx[1]; I_VALID = 1'b1;
            O_READY = !(cyc >= 6 && cyc < 11);
            acc = 1'b0;
            @(negedge C);
            if (I_READY === 1'b1) begin
                exp_q.push_back(model(ra, rb, idx[0], idx[1]));
                acc = 1'b1;
            end
            @(posedge C);
            #1;
            if (acc) idx++;
            cyc++;
        end
        I_VALID = 1'b0;
        O_READY = 1'b1;
        chk("stream_sent", 64'(idx), 64'd10);
        drain();

        // Reset with three beats in flight
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b0, 1'b1);
        send(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1);
        R = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_ovalid", 64'(O_VALID), 64'd0);
        chk("midrst_sum",    64'(SUM),     64'd0);
        chk("midrst_cout",   64'(COUT),    64'd0);
        chk("midrst_iready", 64'(I_READY), 64'd1);
        @(posedge C);
        #1;
        R = 1'b1;
        @(posedge C);
        #1;
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b1);
        measure_latency("latency_after_reset");
        drain();
        repeat (10) @(negedge C);
        chk("no_stale_beats", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
